// File: rtl/key_debounce.sv
// Push-button conditioning: 2-flop synchroniser, per-key debounce FSM and an optional
// single-key ownership lock. Produces registered KEY levels and KEY_EVT rising-edge pulses.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned ONE_HOT_LOCK    = 1
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic [4:0] KEY_RAW,
  output logic [4:0] KEY,
  output logic [4:0] KEY_EVT
);

  localparam int               NumKeys   = 5;
  localparam logic [2:0]       OwnerNone = 3'd7;
  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {StReleased, StPressChk, StPressed, StReleaseChk} state_e;

  logic [4:0]       raw_pressed;
  logic [4:0]       sync1_q, sync2_q;
  state_e           state_q [NumKeys];
  state_e           state_d [NumKeys];
  logic [CNT_W-1:0] cnt_q   [NumKeys];
  logic [CNT_W-1:0] cnt_d   [NumKeys];
  logic [4:0]       qual, qual_nxt;
  logic [2:0]       owner_q, owner_d;
  logic [4:0]       key_q, key_d;
  logic [4:0]       evt_q, evt_d;

  assign raw_pressed = KEY_RAW ^ {5{ACTIVE_LOW != 0}};

  // Per-key debounce: any sample disagreeing with the target restarts from the stable state.
  always_comb begin
    for (int i = 0; i < NumKeys; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = '0;
      unique case (state_q[i])
        StReleased: begin
          if (sync2_q[i]) state_d[i] = StPressChk;
        end
        StPressChk: begin
          if (!sync2_q[i])              state_d[i] = StReleased;
          else if (cnt_q[i] == CntLast) state_d[i] = StPressed;
          else                          cnt_d[i]   = cnt_q[i] + CNT_W'(1);
        end
        StPressed: begin
          if (!sync2_q[i]) state_d[i] = StReleaseChk;
        end
        StReleaseChk: begin
          if (sync2_q[i])               state_d[i] = StPressed;
          else if (cnt_q[i] == CntLast) state_d[i] = StReleased;
          else                          cnt_d[i]   = cnt_q[i] + CNT_W'(1);
        end
        default: state_d[i] = StReleased;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NumKeys; i++) begin
      qual[i]     = (state_q[i] == StPressed) || (state_q[i] == StReleaseChk);
      qual_nxt[i] = (state_d[i] == StPressed) || (state_d[i] == StReleaseChk);
    end
  end

  // Ownership is granted from the current qualified set (one cycle behind), but dropped on the
  // same edge the owner's qualification falls so KEY never shows a stale bit.
  always_comb begin
    owner_d = owner_q;
    if (owner_q == OwnerNone) begin
      for (int i = NumKeys - 1; i >= 0; i--) begin
        if (qual[i]) owner_d = 3'(i);
      end
    end else begin
      for (int i = 0; i < NumKeys; i++) begin
        if ((owner_q == 3'(i)) && !qual_nxt[i]) owner_d = OwnerNone;
      end
    end

    key_d = '0;
    if (ONE_HOT_LOCK != 0) begin
      for (int i = 0; i < NumKeys; i++) begin
        if (owner_d == 3'(i)) key_d[i] = qual_nxt[i];
      end
    end else begin
      key_d = qual_nxt;
    end

    evt_d = key_d & ~key_q;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q <= '0;
      sync2_q <= '0;
      owner_q <= OwnerNone;
      key_q   <= '0;
      evt_q   <= '0;
      for (int i = 0; i < NumKeys; i++) begin
        state_q[i] <= StReleased;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= raw_pressed;
      sync2_q <= sync1_q;
      owner_q <= owner_d;
      key_q   <= key_d;
      evt_q   <= evt_d;
      for (int i = 0; i < NumKeys; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign KEY     = key_q;
  assign KEY_EVT = evt_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed and random checks of key_debounce (locked and unlocked variants) against a
// run-length reference model of the debounce and ownership rules.
module tb_key_debounce;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] key_raw;
  logic [4:0] key_l, evt_l, key_f, evt_f;

  key_debounce #(
    .DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1), .ONE_HOT_LOCK(1)
  ) u_dut_lock (
    .HCLK(clk), .HRESETn(rst_n), .KEY_RAW(key_raw), .KEY(key_l), .KEY_EVT(evt_l)
  );

  key_debounce #(
    .DEBOUNCE_CYCLES(D), .CNT_W(3), .ACTIVE_LOW(1), .ONE_HOT_LOCK(0)
  ) u_dut_free (
    .HCLK(clk), .HRESETn(rst_n), .KEY_RAW(key_raw), .KEY(key_f), .KEY_EVT(evt_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: accepted level per key plus the length of the current disagreeing run.
  logic [4:0] m_s1, m_s2, m_acc;
  int         m_run [5];
  int         m_owner;
  logic [4:0] m_key_l, m_evt_l, m_key_f, m_evt_f;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_acc = '0; m_owner = -1;
    m_key_l = '0; m_evt_l = '0; m_key_f = '0; m_evt_f = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
  endtask

  task automatic model_edge();
    logic [4:0] prev_q, kl, kf;
    if (!rst_n) begin
      model_reset();
      return;
    end
    prev_q = m_acc;
    for (int i = 0; i < 5; i++) begin
      if (m_s2[i] != m_acc[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_acc[i] = m_s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = ~key_raw;
    if (m_owner < 0) begin
      for (int i = 4; i >= 0; i--) if (prev_q[i]) m_owner = i;
    end else if (!m_acc[m_owner]) begin
      m_owner = -1;
    end
    kl = '0;
    if (m_owner >= 0 && m_acc[m_owner]) kl[m_owner] = 1'b1;
    kf = m_acc;
    m_evt_l = kl & ~m_key_l;
    m_evt_f = kf & ~m_key_f;
    m_key_l = kl;
    m_key_f = kf;
  endtask

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("model_key_lock", key_l, m_key_l);
      chk("model_evt_lock", evt_l, m_evt_l);
      chk("model_key_free", key_f, m_key_f);
      chk("model_evt_free", evt_f, m_evt_f);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_key_lock", key_l, 5'h00);
    chk("async_rst_evt_lock", evt_l, 5'h00);
    chk("async_rst_key_free", key_f, 5'h00);
    chk("async_rst_evt_free", evt_f, 5'h00);
    step(2);
    rst_n = 1'b1;
  endtask

  int pulses;

  initial begin
    rst_n   = 1'b0;
    key_raw = 5'h1F;
    model_reset();
    #1;
    chk("reset_key", key_l, 5'h00);
    chk("reset_evt", evt_l, 5'h00);
    step(3);
    rst_n = 1'b1;

    // Idle with all buttons up.
    step(20);
    chk("idle_key", key_l, 5'h00);

    // Clean press and release of key 2.
    key_raw = 5'h1B;
    step(7);
    chk("k2_before_rise", key_l, 5'h00);
    step(1);
    chk("k2_rise_key", key_l, 5'h04);
    chk("k2_rise_evt", evt_l, 5'h04);
    step(1);
    chk("k2_evt_one_cycle", evt_l, 5'h00);
    step(10);
    key_raw = 5'h1F;
    step(6);
    chk("k2_before_fall", key_l, 5'h04);
    step(1);
    chk("k2_fall_key", key_l, 5'h00);
    chk("k2_fall_no_evt", evt_l, 5'h00);
    step(8);

    // Bouncing key 0, then held.
    key_raw = 5'h1E; step(2);
    key_raw = 5'h1F; step(2);
    key_raw = 5'h1E;
    step(7);
    chk("bounce_before_rise", key_l, 5'h00);
    step(1);
    chk("bounce_rise", key_l, 5'h01);
    pulses = (evt_l[0] === 1'b1) ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (evt_l[0] === 1'b1) pulses++;
    end
    chk("bounce_one_pulse", 5'(pulses), 5'd1);
    key_raw = 5'h1F;
    step(12);

    // Keys 3 and 1 together: lowest index owns; its release hands over after a gap.
    key_raw = 5'h15;
    step(7);
    step(1);
    chk("dual_lock_key", key_l, 5'h02);
    chk("dual_free_key", key_f, 5'h0A);
    step(5);
    key_raw = 5'h17;
    step(6);
    chk("k1_still_owned", key_l, 5'h02);
    step(1);
    chk("handover_gap", key_l, 5'h00);
    step(1);
    chk("handover_key", key_l, 5'h08);
    chk("handover_evt", evt_l, 5'h08);
    step(1);
    chk("handover_evt_end", evt_l, 5'h00);
    key_raw = 5'h1F;
    step(12);

    // Reset during qualification of key 4 (counter at 2), then during press.
    key_raw = 5'h0F;
    step(5);
    pulse_reset();
    step(7);
    chk("requal_before", key_l, 5'h00);
    step(1);
    chk("requal_key", key_l, 5'h10);
    chk("requal_evt", evt_l, 5'h10);
    step(3);
    chk("pressed_free_key", key_f, 5'h10);
    pulse_reset();
    step(7);
    chk("requal2_before", key_l, 5'h00);
    step(1);
    chk("requal2_key", key_l, 5'h10);
    key_raw = 5'h1F;
    step(12);

    // Keys 0 and 4 together on the unlocked variant.
    key_raw = 5'h0E;
    step(6);
    chk("free_before", key_f, 5'h00);
    step(1);
    chk("free_rise_key", key_f, 5'h11);
    chk("free_rise_evt", evt_f, 5'h11);
    step(1);
    chk("free_evt_end", evt_f, 5'h00);
    chk("free_lock_key", key_l, 5'h01);
    key_raw = 5'h1F;
    step(12);

    // Random bouncing on all pins.
    for (int r = 0; r < 120; r++) begin
      key_raw = 5'($urandom_range(0, 31));
      step(int'($urandom_range(1, 8)));
    end
    key_raw = 5'h1F;
    step(20);
    chk("final_key", key_l, 5'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
